bus_slave_reg: RTL and testbench

BUS_SLAVE_REG -- requirements
Module: bus_slave_reg

---
 rtl/bus_pkg.sv | 31 +++
 rtl/bus_if.sv | 24 ++
 rtl/slave_regfile.sv | 30 +++
 rtl/bus_slave_reg.sv | 125 ++++++++++++
 tb/tb_bus_slave_reg.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and widths for the bus slave register block.
package bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ADDR_ACK = 2'd1,
    S_WAIT     = 2'd2,
    S_DATA_ACK = 2'd3
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Widened by one bit so BASE+NUM never wraps past 16'hFFFF.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] base,
                                         input int unsigned       num);
    logic [ADDR_W:0] a;
    logic [ADDR_W:0] lo;
    logic [ADDR_W:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + num[ADDR_W:0];
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/bus_if.sv
// Master-to-slave request/acknowledge bus.
interface bus_if
  import bus_pkg::*;
();

  logic              valid;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic              ready;
  logic [DATA_W-1:0] read_data;

  modport master (
    output valid, read, write, addr, write_data,
    input  ready, read_data
  );

  modport slave (
    input  valid, read, write, addr, write_data,
    output ready, read_data
  );

endinterface

// File: rtl/slave_regfile.sv
// Register bank: one synchronous write port, one combinational read port.
module slave_regfile
  import bus_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_we,
  input  logic [idx_width(NUM_REGS)-1:0] i_waddr,
  input  logic [DATA_W-1:0]              i_wdata,
  input  logic [idx_width(NUM_REGS)-1:0] i_raddr,
  output logic [DATA_W-1:0]              o_rdata
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_slave_reg.sv
// Bus slave with a register bank, address/data acknowledge and wait states.
// Optional error flag enabled by defining BUS_SLAVE_ERR_EN.
module bus_slave_reg
  import bus_pkg::*;
#(
  parameter int unsigned       NUM_REGS    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned       WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  bus_if.slave busa
`ifdef BUS_SLAVE_ERR_EN
  ,
  output logic err
`endif
);

  localparam int unsigned IDX_W     = idx_width(NUM_REGS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            r_state;
  state_t            w_next;
  logic              r_cmd_read;
  logic              r_cmd_write;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;
  logic [3:0]        r_cnt;
  logic              r_ready;
  logic [DATA_W-1:0] r_rdata;

  logic              w_eff_read;
  logic              w_eff_write;
  logic [ADDR_W-1:0] w_eff_addr;
  logic              w_rd_in_range;
  logic              w_wr_in_range;
  logic [IDX_W-1:0]  w_ridx;
  logic [IDX_W-1:0]  w_widx;
  logic [DATA_W-1:0] w_rf_rdata;
  logic              w_we;

  // With no wait states DATA_ACK is entered on the same edge that latches the
  // command, so the read decode must look through to the live bus fields.
  assign w_eff_read  = (r_state == S_ADDR_ACK) ? busa.read  : r_cmd_read;
  assign w_eff_write = (r_state == S_ADDR_ACK) ? busa.write : r_cmd_write;
  assign w_eff_addr  = (r_state == S_ADDR_ACK) ? busa.addr  : r_cmd_addr;

  assign w_rd_in_range = addr_in_range(w_eff_addr, BASE_ADDR, NUM_REGS);
  assign w_wr_in_range = addr_in_range(r_cmd_addr, BASE_ADDR, NUM_REGS);
  assign w_ridx        = IDX_W'(w_eff_addr - BASE_ADDR);
  assign w_widx        = IDX_W'(r_cmd_addr - BASE_ADDR);
  assign w_we          = (r_state == S_DATA_ACK) && r_cmd_write && !r_cmd_read && w_wr_in_range;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (busa.valid) w_next = S_ADDR_ACK;
      S_ADDR_ACK: w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_DATA_ACK;
      S_WAIT: begin
        if (!busa.valid)       w_next = S_IDLE;
        else if (r_cnt == '0)  w_next = S_DATA_ACK;
      end
      S_DATA_ACK: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cmd_read  <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_ADDR_ACK) || (w_next == S_DATA_ACK);
      if (r_state == S_ADDR_ACK) begin
        r_cmd_read  <= busa.read;
        r_cmd_write <= busa.write;
        r_cmd_addr  <= busa.addr;
        r_cmd_wdata <= busa.write_data;
        r_cnt       <= WAIT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if ((w_next == S_DATA_ACK) && w_eff_read && !w_eff_write) begin
        r_rdata <= w_rd_in_range ? w_rf_rdata : '0;
      end
    end
  end

  assign busa.ready     = r_ready;
  assign busa.read_data = r_rdata;

`ifdef BUS_SLAVE_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_next == S_DATA_ACK) && (!w_rd_in_range || (w_eff_read == w_eff_write));
    end
  end

  assign err = r_err;
`endif

  slave_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_widx),
    .i_wdata (r_cmd_wdata),
    .i_raddr (w_ridx),
    .o_rdata (w_rf_rdata)
  );

endmodule

// File: tb/tb_bus_slave_reg.sv
// Directed bench for bus_slave_reg: three instances with different wait/base settings.
module tb_bus_slave_reg;
  import bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  int unsigned sel;
  logic        t_valid, t_read, t_write;
  logic [15:0] t_addr;
  logic [31:0] t_wdata;
  logic        m_ready, m_err;
  logic [31:0] m_rdata;

  bus_if b1 ();
  bus_if b3 ();
  bus_if b0 ();

  assign b1.valid = (sel == 1) && t_valid;
  assign b3.valid = (sel == 3) && t_valid;
  assign b0.valid = (sel == 0) && t_valid;
  assign b1.read = t_read;   assign b3.read = t_read;   assign b0.read = t_read;
  assign b1.write = t_write; assign b3.write = t_write; assign b0.write = t_write;
  assign b1.addr = t_addr;   assign b3.addr = t_addr;   assign b0.addr = t_addr;
  assign b1.write_data = t_wdata;
  assign b3.write_data = t_wdata;
  assign b0.write_data = t_wdata;

`ifdef BUS_SLAVE_ERR_EN
  logic e1, e3, e0;
`endif

  bus_slave_reg #(.NUM_REGS(8), .BASE_ADDR(16'h0000), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .busa(b1)
`ifdef BUS_SLAVE_ERR_EN
    , .err(e1)
`endif
  );

  bus_slave_reg #(.NUM_REGS(8), .BASE_ADDR(16'h0000), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .busa(b3)
`ifdef BUS_SLAVE_ERR_EN
    , .err(e3)
`endif
  );

  bus_slave_reg #(.NUM_REGS(4), .BASE_ADDR(16'h0010), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .busa(b0)
`ifdef BUS_SLAVE_ERR_EN
    , .err(e0)
`endif
  );

  always_comb begin
    m_ready = b1.ready;
    m_rdata = b1.read_data;
    m_err   = 1'b0;
    case (sel)
      3: begin m_ready = b3.ready; m_rdata = b3.read_data; end
      0: begin m_ready = b0.ready; m_rdata = b0.read_data; end
      default: ;
    endcase
`ifdef BUS_SLAVE_ERR_EN
    case (sel)
      3:       m_err = e3;
      0:       m_err = e0;
      default: m_err = e1;
    endcase
`endif
  end

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  task automatic txn(input string tag, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [31:0] d, input int w,
                     output logic [31:0] rdata, output logic err);
    int first, second;
    first = -1; second = -1; rdata = '0; err = 1'b0;
    @(posedge clk); #1;
    t_valid = 1'b1; t_read = rd; t_write = wr; t_addr = a; t_wdata = d;
    for (int c = 0; c < 24 && second < 0; c++) begin
      @(negedge clk);
      if (m_ready) begin
        if (first < 0) begin
          first = c;
`ifdef BUS_SLAVE_ERR_EN
          chk({tag, "_aerr"}, m_err, 0);
`endif
        end else begin
          second = c; rdata = m_rdata; err = m_err;
        end
      end
    end
    t_valid = 1'b0; t_read = 1'b0; t_write = 1'b0;
    chk({tag, "_aack"}, first, 1);
    chk({tag, "_dack"}, second, 2 + w);
  endtask

  task automatic chk_err(input string tag, input logic act, input logic exp);
`ifdef BUS_SLAVE_ERR_EN
    chk(tag, act, exp);
`endif
  endtask

  logic [31:0] rd;
  logic        er;
  int          seen;

  initial begin
    reset = 1'b0; sel = 1;
    t_valid = 1'b0; t_read = 1'b0; t_write = 1'b0; t_addr = '0; t_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy1", b1.ready, 0);     chk("rst_rd1", b1.read_data, 0);
    chk("rst_rdy3", b3.ready, 0);     chk("rst_rd0", b0.read_data, 0);
    reset = 1'b1;

    // W=1 bank: reset value, write then read
    txn("rd5", 1, 0, 16'h0005, 0, 1, rd, er);
    chk("rd5_data", rd, 32'h0); chk_err("rd5_err", er, 0);
    txn("wr1", 0, 1, 16'h0001, 32'hDEACBEFF, 1, rd, er);
    chk("wr1_rdhold", rd, 32'h0); chk_err("wr1_err", er, 0);
    txn("rd1", 1, 0, 16'h0001, 0, 1, rd, er);
    chk("rd1_data", rd, 32'hDEACBEFF); chk_err("rd1_err", er, 0);

    // illegal commands: acknowledged, nothing changes
    txn("rw1", 1, 1, 16'h0001, 32'h0, 1, rd, er);
    chk("rw1_rdhold", rd, 32'hDEACBEFF); chk_err("rw1_err", er, 1);
    txn("nop1", 0, 0, 16'h0001, 32'h0, 1, rd, er);
    chk("nop1_rdhold", rd, 32'hDEACBEFF); chk_err("nop1_err", er, 1);

    // out of range
    txn("wr8", 0, 1, 16'h0008, 32'h12345678, 1, rd, er);
    chk_err("wr8_err", er, 1);
    txn("rd8", 1, 0, 16'h0008, 0, 1, rd, er);
    chk("rd8_data", rd, 32'h0); chk_err("rd8_err", er, 1);
    txn("rdffff", 1, 0, 16'hFFFF, 0, 1, rd, er);
    chk("rdffff_data", rd, 32'h0); chk_err("rdffff_err", er, 1);
    for (int i = 0; i < 8; i++) begin
      txn($sformatf("bank%0d", i), 1, 0, 16'(i), 0, 1, rd, er);
      chk($sformatf("bank%0d_data", i), rd, (i == 1) ? 32'hDEACBEFF : 32'h0);
    end

    // W=3 bank: drop valid during the wait phase
    sel = 3; seen = 0;
    @(posedge clk); #1;
    t_valid = 1'b1; t_write = 1'b1; t_addr = 16'h0002; t_wdata = 32'hA5A5A5A5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 1) chk("abort_aack", m_ready, 1);
    end
    t_valid = 1'b0; t_write = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_ready) seen++;
    end
    chk("abort_noack", seen, 0);
    txn("ab_rd2", 1, 0, 16'h0002, 0, 3, rd, er);
    chk("ab_rd2_data", rd, 32'h0);
    txn("w3_wr3", 0, 1, 16'h0003, 32'h0BADF00D, 3, rd, er);
    txn("w3_rd3", 1, 0, 16'h0003, 0, 3, rd, er);
    chk("w3_rd3_data", rd, 32'h0BADF00D);

    // W=0 bank at base 0x10: continuous valid
    sel = 0;
    @(posedge clk); #1;
    t_valid = 1'b1; t_write = 1'b1; t_addr = 16'h0010; t_wdata = 32'h10000000;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_rdy%0d", k), m_ready, (k % 3 != 0) ? 1 : 0);
      if (k % 3 == 2) begin
        if (k == 11) t_valid = 1'b0;
        else begin t_addr = t_addr + 16'd1; t_wdata = t_wdata + 32'd1; end
      end
    end
    t_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      txn($sformatf("b2b_rd%0d", i), 1, 0, 16'h0010 + 16'(i), 0, 0, rd, er);
      chk($sformatf("b2b_rd%0d_data", i), rd, 32'h10000000 + i);
    end
    txn("rd14", 1, 0, 16'h0014, 0, 0, rd, er);
    chk("rd14_data", rd, 32'h0); chk_err("rd14_err", er, 1);
    txn("rd0f", 1, 0, 16'h000F, 0, 0, rd, er);
    chk("rd0f_data", rd, 32'h0); chk_err("rd0f_err", er, 1);

    // W=1 bank: reset during the data acknowledge of a write
    sel = 1;
    @(posedge clk); #1;
    t_valid = 1'b1; t_write = 1'b1; t_addr = 16'h0004; t_wdata = 32'hCAFEF00D;
    for (int c = 0; c < 4; c++) @(negedge clk);
    chk("mid_dack", m_ready, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_rdy", m_ready, 0);
    t_valid = 1'b0; t_write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    txn("post_rd4", 1, 0, 16'h0004, 0, 1, rd, er);
    chk("post_rd4_data", rd, 32'h0);
    txn("post_rd1", 1, 0, 16'h0001, 0, 1, rd, er);
    chk("post_rd1_data", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
